// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner select for a shared tri-state bus with all-off turnaround gaps
// Ports:
//   clk      - rising-edge clock
//   rstn     - asynchronous active-low reset
//   req      - per-requester level-sensitive bus request
//   gnt      - one-hot registered grant, active-high
//   oe_n     - active-low tri-state enables, always ~gnt
//   owner_id - index of current or most recent owner
//   busy     - high while a grant is active
//   turn     - high during the all-off turnaround gap
module tristate_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         oe_n,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy,
  output logic                     turn
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d, ptr_q, ptr_d, win;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             found;
  int               idx;
  // Scan from the highest offset down so the requester closest to ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = int'(ptr_q) + j;
      idx = idx >= N_REQ ? idx - N_REQ : idx;
      if (req[IW'(idx)]) begin
        found = 1'b1;
        win = IW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    tcnt_d = tcnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d = N_REQ'(1) << win;
          owner_d = win;
          hold_d = HW'(1);
        end
      end
      GRANT: begin
        if (!req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
          state_d = TURN;
          gnt_d = '0;
          tcnt_d = TW'(1);
          // Moving ptr past the old owner puts it behind every other requester.
          ptr_d = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        if (tcnt_q < TW'(TURN_CYCLES)) begin
          tcnt_d = tcnt_q + 1'b1;
        end else if (found) begin
          state_d = GRANT;
          gnt_d = N_REQ'(1) << win;
          owner_d = win;
          hold_d = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign gnt = gnt_q;
  assign oe_n = ~gnt_q;
  assign owner_id = owner_q;
  assign busy = state_q == GRANT;
  assign turn = state_q == TURN;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: scenario tasks plus randomized run against a tenure/gap reference model
module tb_tristate_bus_arbiter;
  localparam int N = 4;
  localparam int MH = 8;
  localparam int TC = 2;
  logic         clk = 1'b0;
  logic         clk_en = 1'b1;
  logic         rstn = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt, oe_n;
  logic [1:0]   owner_id;
  logic         busy, turn;
  int           errors = 0;
  int           checks = 0;

  always #5 if (clk_en) clk = ~clk;

  tristate_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .oe_n(oe_n),
    .owner_id(owner_id), .busy(busy), .turn(turn)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    rstn = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b want 1", busy);
    if (busy !== 1'b1) errors++;
    clk_en = 1'b0;
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, oe_n, busy, turn, owner_id} !== {4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: gnt=%b oe_n=%b busy=%b turn=%b owner=%0d want 0000 1111 0 0 0",
               gnt, oe_n, busy, turn, owner_id);
    end
    req = '0;
    #3 rstn = 1'b1;
    #2 clk_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || oe_n !== 4'b1111 || busy !== 1'b0 || turn !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: gnt=%b oe_n=%b busy=%b turn=%b want 0000 1111 0 0",
                 gnt, oe_n, busy, turn);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] eg;
    for (int i = 0; i < 7; i++) begin
      req = i < 4 ? 4'b0100 : 4'b0000;
      @(negedge clk);
      eg = i < 4 ? 4'b0100 : 4'b0000;
      checks++;
      if (gnt !== eg || oe_n !== ~eg || busy !== (i < 4) || turn !== (i == 4 || i == 5) || owner_id !== 2'd2) begin
        errors++;
        $display("FAIL single_req edge %0d: gnt=%b oe_n=%b busy=%b turn=%b owner=%0d want gnt=%b busy=%b turn=%b owner=2",
                 i, gnt, oe_n, busy, turn, owner_id, eg, i < 4, i == 4 || i == 5);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] eg;
    int o;
    apply_reset();
    for (int n = 0; n < 70; n++) begin
      req = n < 38 ? 4'b1111 : n < 41 ? 4'b1001 : 4'b0001;
      @(negedge clk);
      o = n < 40 ? n / 10 : 0;
      eg = (n % 10) < 8 ? 4'(1 << o) : 4'b0000;
      checks++;
      if (gnt !== eg || oe_n !== ~gnt || !$onehot0(gnt) || (busy && turn) ||
          turn !== ((n % 10) >= 8) || owner_id !== 2'(o)) begin
        errors++;
        $display("FAIL contention edge %0d: gnt=%b oe_n=%b busy=%b turn=%b owner=%0d want gnt=%b owner=%0d",
                 n, gnt, oe_n, busy, turn, owner_id, eg, o);
      end
    end
  endtask

  task automatic test_turn_arrival();
    logic [N-1:0] rq [8];
    logic [N-1:0] eg [8];
    rq = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      req = rq[n];
      @(negedge clk);
      checks++;
      if (gnt !== eg[n] || oe_n !== ~eg[n] || turn !== (n == 3 || n == 4) || busy !== (eg[n] != 0)) begin
        errors++;
        $display("FAIL turn_arrival edge %0d: gnt=%b turn=%b busy=%b want gnt=%b turn=%b",
                 n, gnt, turn, busy, eg[n], n == 3 || n == 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0100;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_pre: gnt=%b busy=%b want 0100 1", gnt, busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || oe_n !== 4'b1111 || busy !== 1'b0 || turn !== 1'b0 || owner_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_async_reset: gnt=%b oe_n=%b busy=%b turn=%b owner=%0d want 0000 1111 0 0 0",
               gnt, oe_n, busy, turn, owner_id);
    end
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || oe_n !== 4'b1111) begin
      errors++;
      $display("FAIL mid_held_reset: gnt=%b oe_n=%b want 0000 1111", gnt, oe_n);
    end
    #2 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || oe_n !== 4'b1101 || owner_id !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_regrant: gnt=%b oe_n=%b owner=%0d busy=%b want 0010 1101 1 1",
               gnt, oe_n, owner_id, busy);
    end
  endtask

  // Model: an owner with a tenure length, or no owner with a count of gap edges still to come.
  task automatic test_random();
    logic [N-1:0] r = '0;
    logic [N-1:0] eg;
    int mo = -1, ml = 0, mg = 0, mp = 0, mid = 0, w;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0) ? ~r[b] : r[b];
      req = r;
      @(posedge clk);
      if (mo >= 0) begin
        if (!r[mo] || ml == MH) begin
          mp = (mo + 1) % N;
          mo = -1;
          mg = TC;
        end else begin
          ml++;
        end
      end else if (mg > 1) begin
        mg--;
      end else begin
        mg = 0;
        w = -1;
        for (int j = 0; j < N; j++) begin
          if (r[(mp + j) % N]) begin
            w = (mp + j) % N;
            break;
          end
        end
        if (w >= 0) begin
          mo = w;
          ml = 1;
          mid = w;
        end
      end
      @(negedge clk);
      eg = mo >= 0 ? 4'(1 << mo) : 4'b0000;
      checks++;
      if (gnt !== eg || oe_n !== ~eg || busy !== (mo >= 0) || turn !== (mo < 0 && mg > 0) || owner_id !== 2'(mid)) begin
        errors++;
        $display("FAIL random cycle %0d req=%b: gnt=%b oe_n=%b busy=%b turn=%b owner=%0d want gnt=%b busy=%b turn=%b owner=%0d",
                 c, r, gnt, oe_n, busy, turn, owner_id, eg, mo >= 0, mo < 0 && mg > 0, mid);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_turn_arrival();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one tri-state bus between N_REQ drivers.
- Each driver is an active-low-enable tri-state buffer (bufif0-style); this block generates those enables.
- Guarantees that at most one driver is enabled at any time.
- Inserts a programmable all-off turnaround gap between owners, so one driver's turn-off delay cannot overlap the next driver's turn-on.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure (>=1).
- TURN_CYCLES, 2: all-off turnaround cycles after every tenure (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level-sensitive.
- gnt  output  N_REQ  one-hot grant, active-high.
- oe_n  output  N_REQ  tri-state enables, active-low; always equals ~gnt.
- owner_id  output  $clog2(N_REQ)  index of current or last owner.
- busy  output  1  high while in GRANT.
- turn  output  1  high while in TURN.

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered; no combinational path from req to any output.
- Reset state (applied immediately on rstn low, without a clock edge):
  - state=IDLE, gnt=0, oe_n=all 1, owner_id=0, busy=0, turn=0.
  - Round-robin pointer ptr=0, hold_cnt=0, turn_cnt=0.
- Arbitration: the winner is the first asserted req[i] scanning i=ptr, ptr+1, ... modulo N_REQ (wraps from N_REQ-1 to 0).
- State machine (IDLE, GRANT, TURN):
  - IDLE: at an edge where req!=0, arbitrate. Winner k gets gnt[k]=1, oe_n[k]=0, owner_id=k, busy=1, hold_cnt=1, state=GRANT. Latency is 1 edge from sampled req to gnt. If req==0, stay in IDLE.
  - GRANT, owner k, at each edge:
    - if req[k]==0, or hold_cnt==MAX_HOLD: go to TURN. Set gnt=0, oe_n=all 1, busy=0, turn=1, turn_cnt=1, ptr=(k+1) mod N_REQ.
    - otherwise hold_cnt++.
  - TURN, at each edge:
    - if turn_cnt<TURN_CYCLES: turn_cnt++.
    - otherwise turn=0. If req!=0, arbitrate and go directly to GRANT (no IDLE cycle). Else go to IDLE.
- Resulting tenure length:
  - With req[k] held continuously, gnt[k] is high for exactly MAX_HOLD cycles.
  - If req[k] is sampled low at the m-th GRANT edge, gnt[k] is high for m cycles.
  - With continuous contention, a slot repeats every MAX_HOLD+TURN_CYCLES cycles.
- Preemption: when MAX_HOLD is reached with req[k] still high, k moves behind every other requester via the ptr update. k may win again immediately only if no other req is asserted.
- req changes during TURN are ignored until the final TURN edge. A req pulse that is never high at a sampling edge is lost.
- Invariants, checked every cycle:
  - $onehot0(gnt), and oe_n==~gnt.
  - gnt==0 whenever state!=GRANT.
  - busy and turn are never both 1.
- Reset asserted mid-GRANT or mid-TURN releases the bus at once (oe_n=all 1). After reset, arbitration restarts from ptr=0.
- owner_id holds its value through TURN and IDLE and updates only on a new grant.

Test Plan:
- Reset: drive rstn low mid-cycle with clk stopped. oe_n=4'b1111, gnt=0, busy=0, turn=0 immediately. After release with req=0, the block stays in IDLE.
- Single short request: req=4'b0100 sampled high at edges E..E+3 and low at E+4.
  - gnt=4'b0100 and oe_n=4'b1011 from E to E+4 (4 cycles), owner_id=2.
  - turn=1 from E+4 to E+6, then IDLE with gnt=0.
- Full contention: req=4'b1111 held, defaults.
  - Grants go 0,1,2,3,0; each gnt is high 8 cycles, separated by 2 all-off cycles (10-cycle period).
  - Bench checks $onehot0(gnt) and oe_n==~gnt every cycle.
- Preemption and wrap: after owner 3's tenure, req=4'b1001 → next owner is 0 (ptr wrapped to 0).
  - With req=4'b0001 held alone, owner 0 regains the bus after each 2-cycle TURN, giving repeated 8-cycle grants.
- Request arriving in TURN: req[1] rises during owner 0's TURN. gnt[1] asserts at the final TURN edge, with no IDLE cycle.
- Reset mid-tenure: rstn low at GRANT hold_cnt=5.
  - oe_n goes to all 1 asynchronously.
  - After release with req=4'b0010, gnt=4'b0010 arrives one edge later.
